// File: rtl/onchip_ram_arbiter.sv
// onchip_ram_arbiter
//   Shares one single-port 128K x 32 on-chip RAM between two Avalon-MM style
//   masters (M0, M1). One master is granted per cycle. Arbitration is
//   round-robin, and a bounded hold lets the current owner keep the RAM for at
//   most MAX_HOLD consecutive grants while the other master is waiting.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   mN_address/byteenable/read/    request side of master N (N = 0, 1)
//   write/writedata
//   mN_waitrequest                 1 = request of master N not accepted
//   mN_readdata/readdatavalid      read return to master N
//   ram_*                          RAM port (chipselect high only with a grant)
//   ram_readdata                   RAM q, one cycle after the address
//   conflict_count                 saturating count of both-requesting cycles
module onchip_ram_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [16:0]      m0_address,
  input  logic [3:0]       m0_byteenable,
  input  logic             m0_read,
  input  logic             m0_write,
  input  logic [31:0]      m0_writedata,
  output logic             m0_waitrequest,
  output logic [31:0]      m0_readdata,
  output logic             m0_readdatavalid,
  input  logic [16:0]      m1_address,
  input  logic [3:0]       m1_byteenable,
  input  logic             m1_read,
  input  logic             m1_write,
  input  logic [31:0]      m1_writedata,
  output logic             m1_waitrequest,
  output logic [31:0]      m1_readdata,
  output logic             m1_readdatavalid,
  output logic [16:0]      ram_address,
  output logic [3:0]       ram_byteenable,
  output logic             ram_chipselect,
  output logic             ram_write,
  output logic [31:0]      ram_writedata,
  input  logic [31:0]      ram_readdata,
  output logic [CNT_W-1:0] conflict_count
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [3:0]        hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rvld_q, rvld_d;   // read accepted last cycle
  logic              rown_q, rown_d;   // which master that read belongs to

  logic req0, req1;
  logic gnt_vld, gnt_sel;
  logic hold_ok;
  logic g_read, g_write;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign hold_ok = (hold_q < HOLD_MAX);

  // Grant decision and next-state
  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = 1'b0;
    state_d = IDLE;
    rr_d    = rr_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    rvld_d  = 1'b0;
    rown_d  = rown_q;

    case (state_q)
      OWN0: begin
        if (req0 && (!req1 || hold_ok)) begin
          gnt_vld = 1'b1; gnt_sel = 1'b0;
        end else if (req1) begin
          gnt_vld = 1'b1; gnt_sel = 1'b1;
        end
      end
      OWN1: begin
        if (req1 && (!req0 || hold_ok)) begin
          gnt_vld = 1'b1; gnt_sel = 1'b1;
        end else if (req0) begin
          gnt_vld = 1'b1; gnt_sel = 1'b0;
        end
      end
      default: begin
        if (req0 && req1) begin
          gnt_vld = 1'b1; gnt_sel = rr_q;
        end else if (req0 || req1) begin
          gnt_vld = 1'b1; gnt_sel = req1;
        end
      end
    endcase

    g_write = gnt_sel ? m1_write : m0_write;
    g_read  = gnt_sel ? m1_read  : m0_read;

    if (gnt_vld) begin
      state_d = gnt_sel ? OWN1 : OWN0;
      rr_d    = ~gnt_sel;
      // A repeat grant extends the streak (saturating); an owner change restarts it.
      if (state_q == (gnt_sel ? OWN1 : OWN0))
        hold_d = hold_ok ? hold_q + 4'd1 : hold_q;
      else
        hold_d = 4'd1;
      // Write wins over a simultaneous read, so only pure reads return data.
      rvld_d = g_read & ~g_write;
      rown_d = gnt_sel;
    end

    if (req0 && req1 && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      hold_q  <= 4'd0;
      cnt_q   <= '0;
      rvld_q  <= 1'b0;
      rown_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      rvld_q  <= rvld_d;
      rown_q  <= rown_d;
    end
  end

  // RAM port: granted master's request, all zero without a grant
  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    ram_write      = 1'b0;
    ram_chipselect = gnt_vld;
    if (gnt_vld) begin
      ram_address    = gnt_sel ? m1_address    : m0_address;
      ram_byteenable = gnt_sel ? m1_byteenable : m0_byteenable;
      ram_writedata  = gnt_sel ? m1_writedata  : m0_writedata;
      ram_write      = g_write;
    end
  end

  assign m0_waitrequest   = ~(gnt_vld & ~gnt_sel);
  assign m1_waitrequest   = ~(gnt_vld &  gnt_sel);
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rvld_q & ~rown_q;
  assign m1_readdatavalid = rvld_q &  rown_q;
  assign conflict_count   = cnt_q;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
module tb_onchip_ram_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [16:0] addr_r [2];
  logic [3:0]  be_r   [2];
  logic        rd_r   [2];
  logic        wr_r   [2];
  logic [31:0] wd_r   [2];

  logic             m0_waitrequest, m1_waitrequest;
  logic [31:0]      m0_readdata, m1_readdata;
  logic             m0_readdatavalid, m1_readdatavalid;
  logic [16:0]      ram_address;
  logic [3:0]       ram_byteenable;
  logic             ram_chipselect, ram_write;
  logic [31:0]      ram_writedata;
  logic [31:0]      ram_q = '0;
  logic [CNT_W-1:0] conflict_count;

  onchip_ram_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .m0_address(addr_r[0]), .m0_byteenable(be_r[0]), .m0_read(rd_r[0]),
    .m0_write(wr_r[0]), .m0_writedata(wd_r[0]), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(addr_r[1]), .m1_byteenable(be_r[1]), .m1_read(rd_r[1]),
    .m1_write(wr_r[1]), .m1_writedata(wd_r[1]), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_q),
    .conflict_count(conflict_count)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // RAM slave as seen by the DUT
  logic [31:0] ram [0:131071];
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) ram[ram_address] <= merge(ram[ram_address], ram_writedata, ram_byteenable);
      else           ram_q <= ram[ram_address];
    end
  end

  // Reference model state
  logic [31:0] mdl [0:131071];
  int          last_own;   // -1: nobody was granted last cycle
  int          streak;     // consecutive grants to last_own
  int          rr_m;
  longint      cnt_m;
  bit          pend_vld;
  int          pend_own;
  logic [31:0] pend_data;
  int          lastg;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (r1 && !r0)  return 1;
    if (last_own < 0)         return rr_m;
    if (streak < MAX_HOLD)    return last_own;
    return 1 - last_own;
  endfunction

  task automatic model_reset();
    last_own = -1; streak = 0; rr_m = 0; cnt_m = 0; pend_vld = 0; pend_own = 0; lastg = -1;
  endtask

  task automatic set_req(input int n, input bit rd, input bit wr, input logic [16:0] a,
                         input logic [3:0] be, input logic [31:0] d);
    rd_r[n] = rd; wr_r[n] = wr; addr_r[n] = a; be_r[n] = be; wd_r[n] = d;
  endtask

  task automatic clear_all();
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
  endtask

  // One clock cycle: compare at mid-cycle, advance the model, return after the edge.
  task automatic run_cycle();
    bit r0, r1;
    int g;
    @(negedge clk); #1;
    r0 = rd_r[0] | wr_r[0];
    r1 = rd_r[1] | wr_r[1];
    g  = model_grant(r0, r1);
    chk("wait0", m0_waitrequest, g != 0);
    chk("wait1", m1_waitrequest, g != 1);
    chk("cs", ram_chipselect, g >= 0);
    if (g >= 0) begin
      chk("addr", ram_address, addr_r[g]);
      chk("be", ram_byteenable, be_r[g]);
      chk("wdata", ram_writedata, wd_r[g]);
      chk("we", ram_write, wr_r[g]);
    end else begin
      chk("addr_idle", {ram_address, ram_byteenable, ram_writedata, ram_write}, '0);
    end
    chk("rvalid0", m0_readdatavalid, pend_vld && pend_own == 0);
    chk("rvalid1", m1_readdatavalid, pend_vld && pend_own == 1);
    if (pend_vld) chk("rdata", pend_own ? m1_readdata : m0_readdata, pend_data);
    chk("conflicts", 64'(conflict_count), 64'(cnt_m));

    pend_vld = (g >= 0) && rd_r[g] && !wr_r[g];
    if (pend_vld) begin
      pend_own  = g;
      pend_data = mdl[addr_r[g]];
    end
    if (g >= 0 && wr_r[g]) mdl[addr_r[g]] = merge(mdl[addr_r[g]], wd_r[g], be_r[g]);
    if (r0 && r1 && cnt_m < (64'd1 << CNT_W) - 1) cnt_m++;
    if (g >= 0) begin
      streak   = (g == last_own) ? ((streak < MAX_HOLD) ? streak + 1 : streak) : 1;
      rr_m     = 1 - g;
      last_own = g;
    end else begin
      last_own = -1;
    end
    lastg = g;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_all();
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_rv0", m0_readdatavalid, 1'b0);
    chk("rst_rv1", m1_readdatavalid, 1'b0);
    chk("rst_cnt", 64'(conflict_count), 64'd0);
    chk("rst_wait0", m0_waitrequest, 1'b1);
    chk("rst_wait1", m1_waitrequest, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [16:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return 17'h1FFFF;
    return 17'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < 131072; i++) begin
      ram[i] = '0;
      mdl[i] = '0;
    end
    clear_all();
    model_reset();
    do_reset();

    // Single master write then read
    set_req(0, 0, 1, 17'h00010, 4'hF, 32'hDEADBEEF);
    run_cycle();
    set_req(0, 1, 0, 17'h00010, 4'hF, '0);
    run_cycle();
    clear_all();
    chk("t1_rv0", m0_readdatavalid, 1'b1);
    chk("t1_data", m0_readdata, 32'hDEADBEEF);
    chk("t1_rv1", m1_readdatavalid, 1'b0);
    run_cycle();

    // Simultaneous single reads after reset
    do_reset();
    set_req(0, 1, 0, 17'h00010, 4'hF, '0);
    set_req(1, 1, 0, 17'h00020, 4'hF, '0);
    run_cycle();
    chk("t2_g0", 64'(lastg), 64'd0);
    set_req(0, 0, 0, '0, '0, '0);
    run_cycle();
    chk("t2_g1", 64'(lastg), 64'd1);
    clear_all();
    run_cycle();
    chk("t2_cnt", 64'(conflict_count), 64'd1);

    // Both masters stream reads
    do_reset();
    for (int n = 0; n < 2; n++) set_req(n, 1, 0, rnd_addr(), 4'hF, '0);
    for (int i = 0; i < 24; i++) begin
      run_cycle();
      chk("t3_seq", 64'(lastg), 64'((i / MAX_HOLD) % 2));
      set_req(lastg, 1, 0, rnd_addr(), 4'hF, '0);
    end
    clear_all();
    run_cycle();

    // Byte lanes, including the top word
    for (int k = 0; k < 2; k++) begin
      logic [16:0] a;
      a = (k == 0) ? 17'h00030 : 17'h1FFFF;
      set_req(1, 0, 1, a, 4'hF, 32'hFFFFFFFF);
      run_cycle();
      set_req(1, 0, 1, a, 4'h3, 32'h12345678);
      run_cycle();
      set_req(1, 1, 0, a, 4'hF, '0);
      run_cycle();
      clear_all();
      chk("t4_rv1", m1_readdatavalid, 1'b1);
      chk("t4_data", m1_readdata, 32'hFFFF5678);
      run_cycle();
    end

    // Reset right after a read is accepted
    set_req(0, 1, 0, 17'h00010, 4'hF, '0);
    set_req(1, 1, 0, 17'h00020, 4'hF, '0);
    run_cycle();
    clear_all();
    reset = 1'b1;
    @(negedge clk); #1;
    chk("t5_rv0", m0_readdatavalid, 1'b0);
    chk("t5_rv1", m1_readdatavalid, 1'b0);
    chk("t5_cnt", 64'(conflict_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    set_req(0, 1, 0, 17'h00011, 4'hF, '0);
    set_req(1, 1, 0, 17'h00021, 4'hF, '0);
    run_cycle();
    chk("t5_g", 64'(lastg), 64'd0);
    clear_all();
    run_cycle();
    run_cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (lastg == n || !(rd_r[n] | wr_r[n])) begin
          int k;
          k = $urandom_range(0, 7);
          set_req(n, k inside {[3:4], 7}, k >= 5, rnd_addr(), 4'($urandom_range(0, 15)), $urandom);
        end
      end
      run_cycle();
    end
    clear_all();
    run_cycle();

    // Contention counter saturation
    do_reset();
    for (int n = 0; n < 2; n++) set_req(n, 1, 0, rnd_addr(), 4'hF, '0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      run_cycle();
      set_req(lastg, 1, 0, rnd_addr(), 4'hF, '0);
    end
    clear_all();
    run_cycle();
    chk("t6_sat", 64'(conflict_count), 64'((1 << CNT_W) - 1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
